// File: rtl/cpureset_sequencer.sv
// CPU reset-request sequencer: synchronises masked request sources and drives the Nios II
// resetrequest/resettaken handshake, with a hard-reset fallback when the CPU never acknowledges.
module cpureset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int NUM_SRC        = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int GUARD_CYCLES   = 8
) (
    input  logic               clock_core_sig,
    input  logic               qsys_reset_n_sig,
    input  logic [NUM_SRC-1:0] req_async,
    input  logic [NUM_SRC-1:0] src_mask,
    input  logic               cpu_resettaken,
    input  logic               clear_status,
    output logic               cpu_resetrequest,
    output logic               hard_reset_n,
    output logic               busy,
    output logic [NUM_SRC-1:0] cause,
    output logic               timeout_flag
);

    localparam int MAX_TH = (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
    localparam int MAX_C  = (MAX_TH > GUARD_CYCLES) ? MAX_TH : GUARD_CYCLES;
    localparam int CW     = $clog2(MAX_C) + 1;

    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, REQ, HOLD, FORCE, RELEASE} state_t;

    state_t                              state;
    logic [CW-1:0]                       cnt;
    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
    logic [NUM_SRC-1:0]                  req_sync;
    logic [NUM_SRC-1:0]                  req_masked;
    logic                                req_any;

    // Stage 0 takes the raw level; the last stage is the only one safe to use.
    always_ff @(posedge clock_core_sig or negedge qsys_reset_n_sig) begin
        if (!qsys_reset_n_sig) sync_q <= '0;
        else                   sync_q <= {sync_q[SYNC_STAGES-2:0], req_async};
    end

    assign req_sync   = sync_q[SYNC_STAGES-1];
    assign req_masked = req_sync & ~src_mask;
    assign req_any    = |req_masked;

    always_ff @(posedge clock_core_sig or negedge qsys_reset_n_sig) begin
        if (!qsys_reset_n_sig) begin
            state            <= IDLE;
            cnt              <= '0;
            cpu_resetrequest <= 1'b0;
            hard_reset_n     <= 1'b1;
            busy             <= 1'b0;
            cause            <= '0;
            timeout_flag     <= 1'b0;
        end else begin
            // Status clears first so a same-cycle capture or timeout overrides it.
            if (clear_status) begin
                cause        <= '0;
                timeout_flag <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (req_any) begin
                        state            <= REQ;
                        cnt              <= '0;
                        cpu_resetrequest <= 1'b1;
                        busy             <= 1'b1;
                        cause            <= (clear_status ? '0 : cause) | req_masked;
                    end
                end
                REQ: begin
                    if (cpu_resettaken) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end else if (cnt == TO_LAST) begin
                        state        <= FORCE;
                        cnt          <= '0;
                        hard_reset_n <= 1'b0;
                        timeout_flag <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD, FORCE: begin
                    // A source still asserting keeps the CPU in reset past the minimum hold.
                    if (cnt == HOLD_LAST) begin
                        if (!req_any) begin
                            state            <= RELEASE;
                            cnt              <= '0;
                            cpu_resetrequest <= 1'b0;
                            hard_reset_n     <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt == GUARD_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state            <= IDLE;
                    cnt              <= '0;
                    cpu_resetrequest <= 1'b0;
                    hard_reset_n     <= 1'b1;
                    busy             <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpureset_sequencer.sv
// Scoreboard bench: expected output transitions are queued with their edge number when
// stimulus is driven, and popped as the monitor sees the DUT outputs change.
module tb_cpureset_sequencer;

    localparam int RQ_RISE = 0, RQ_FALL = 1, HR_FALL = 2, HR_RISE = 3, BZ_RISE = 4, BZ_FALL = 5;

    logic       clock_core_sig   = 1'b0;
    logic       qsys_reset_n_sig = 1'b0;
    logic [1:0] req_async        = '0;
    logic [1:0] src_mask         = '0;
    logic       cpu_resettaken   = 1'b0;
    logic       clear_status     = 1'b0;
    logic       cpu_resetrequest;
    logic       hard_reset_n;
    logic       busy;
    logic [1:0] cause;
    logic       timeout_flag;

    cpureset_sequencer dut (
        .clock_core_sig  (clock_core_sig),
        .qsys_reset_n_sig(qsys_reset_n_sig),
        .req_async       (req_async),
        .src_mask        (src_mask),
        .cpu_resettaken  (cpu_resettaken),
        .clear_status    (clear_status),
        .cpu_resetrequest(cpu_resetrequest),
        .hard_reset_n    (hard_reset_n),
        .busy            (busy),
        .cause           (cause),
        .timeout_flag    (timeout_flag)
    );

    always #5 clock_core_sig = ~clock_core_sig;

    int edges = 0;
    always @(posedge clock_core_sig) edges++;

    typedef struct {int kind; int cyc;} ev_t;
    ev_t sbq[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (edge %0d)", tag, obs, exp, edges);
        end
    endtask

    task automatic push(input int k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        sbq.push_back(e);
    endtask

    task automatic note(input int k);
        ev_t e;
        if (sbq.size() == 0) begin
            chk("unexpected_event", k, 32'hFFFF_FFFF);
        end else begin
            e = sbq.pop_front();
            chk("event_kind", k, e.kind);
            chk("event_edge", edges, e.cyc);
        end
    endtask

    task automatic to_edge(input int e);
        while (edges < e) @(negedge clock_core_sig);
    endtask

    task automatic pulse_clear();
        clear_status = 1'b1;
        @(negedge clock_core_sig);
        clear_status = 1'b0;
    endtask

    logic mon_en = 1'b0;
    logic p_rq, p_hr, p_bz;
    always @(negedge clock_core_sig) begin
        if (mon_en) begin
            if (cpu_resetrequest !== p_rq) note(cpu_resetrequest ? RQ_RISE : RQ_FALL);
            if (hard_reset_n !== p_hr)     note(hard_reset_n ? HR_RISE : HR_FALL);
            if (busy !== p_bz)             note(busy ? BZ_RISE : BZ_FALL);
            p_rq = cpu_resetrequest;
            p_hr = hard_reset_n;
            p_bz = busy;
        end
    end

    int e0, n, f;

    initial begin
        repeat (3) @(negedge clock_core_sig);
        chk("rst_rq", cpu_resetrequest, 0);
        chk("rst_hr", hard_reset_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_cause", cause, 0);
        chk("rst_tf", timeout_flag, 0);
        qsys_reset_n_sig = 1'b1;
        p_rq = 1'b0; p_hr = 1'b1; p_bz = 1'b0;
        mon_en = 1'b1;
        @(negedge clock_core_sig);

        // Acknowledged sequence from source 0
        e0 = edges;
        req_async[0] = 1'b1;
        push(RQ_RISE, e0 + 3); push(BZ_RISE, e0 + 3);
        to_edge(e0 + 4); req_async[0] = 1'b0;
        to_edge(e0 + 8); cpu_resettaken = 1'b1;
        n = edges + 1;
        push(RQ_FALL, n + 16); push(BZ_FALL, n + 24);
        @(negedge clock_core_sig); cpu_resettaken = 1'b0;
        to_edge(n + 15); chk("t1_hold_rq", cpu_resetrequest, 1);
        to_edge(n + 20); chk("t1_guard_busy", busy, 1);
        to_edge(n + 25);
        chk("t1_cause", cause, 2'b01);
        chk("t1_idle_busy", busy, 0);
        pulse_clear();
        chk("t1_cleared", cause, 0);

        // Never acknowledged: timeout into FORCE
        e0 = edges;
        req_async[0] = 1'b1;
        f = e0 + 3 + 1024;
        push(RQ_RISE, e0 + 3); push(BZ_RISE, e0 + 3);
        push(HR_FALL, f);
        push(RQ_FALL, f + 16); push(HR_RISE, f + 16);
        push(BZ_FALL, f + 24);
        to_edge(e0 + 4); req_async[0] = 1'b0;
        to_edge(f - 1); chk("t2_pre_hr", hard_reset_n, 1);
        to_edge(f + 1);
        chk("t2_hr", hard_reset_n, 0);
        chk("t2_tf", timeout_flag, 1);
        to_edge(f + 25);
        chk("t2_tf_sticky", timeout_flag, 1);
        pulse_clear();
        chk("t2_tf_clr", timeout_flag, 0);
        chk("t2_cause_clr", cause, 0);

        // Masked source produces nothing
        src_mask = 2'b10;
        e0 = edges;
        req_async[1] = 1'b1;
        to_edge(e0 + 4); req_async[1] = 1'b0;
        to_edge(e0 + 12);
        chk("t3_busy", busy, 0);
        chk("t3_cause", cause, 0);
        src_mask = 2'b00;
        to_edge(e0 + 16);

        // Source 1 held across HOLD extends it until the sync'd level drops
        e0 = edges;
        req_async[1] = 1'b1;
        push(RQ_RISE, e0 + 3); push(BZ_RISE, e0 + 3);
        to_edge(e0 + 8); cpu_resettaken = 1'b1;
        @(negedge clock_core_sig); cpu_resettaken = 1'b0;
        to_edge(e0 + 60); chk("t4_ext_rq", cpu_resetrequest, 1);
        to_edge(e0 + 100); req_async[1] = 1'b0;
        push(RQ_FALL, e0 + 103); push(BZ_FALL, e0 + 111);
        to_edge(e0 + 102); chk("t4_still_rq", cpu_resetrequest, 1);
        to_edge(e0 + 112);
        chk("t4_cause", cause, 2'b10);
        pulse_clear();

        // Request arriving during RELEASE waits for IDLE, then re-triggers
        e0 = edges;
        req_async[0] = 1'b1;
        push(RQ_RISE, e0 + 3); push(BZ_RISE, e0 + 3);
        to_edge(e0 + 4); req_async[0] = 1'b0;
        to_edge(e0 + 8); cpu_resettaken = 1'b1;
        n = edges + 1;
        f = n + 16;
        push(RQ_FALL, f); push(BZ_FALL, f + 8);
        push(RQ_RISE, f + 9); push(BZ_RISE, f + 9);
        @(negedge clock_core_sig); cpu_resettaken = 1'b0;
        to_edge(f + 2); req_async[0] = 1'b1;
        to_edge(f + 6);
        chk("t5_rel_rq", cpu_resetrequest, 0);
        chk("t5_rel_busy", busy, 1);
        to_edge(f + 12); req_async[0] = 1'b0;
        to_edge(f + 14); cpu_resettaken = 1'b1;
        n = edges + 1;
        push(RQ_FALL, n + 16); push(BZ_FALL, n + 24);
        @(negedge clock_core_sig); cpu_resettaken = 1'b0;
        to_edge(n + 25);
        chk("t5_idle", busy, 0);
        pulse_clear();

        // Asynchronous reset in the middle of REQ
        e0 = edges;
        req_async[0] = 1'b1;
        push(RQ_RISE, e0 + 3); push(BZ_RISE, e0 + 3);
        to_edge(e0 + 4); req_async[0] = 1'b0;
        to_edge(e0 + 5);
        #2 qsys_reset_n_sig = 1'b0;
        #1;
        chk("t6_rq", cpu_resetrequest, 0);
        chk("t6_hr", hard_reset_n, 1);
        chk("t6_busy", busy, 0);
        chk("t6_cause", cause, 0);
        chk("t6_tf", timeout_flag, 0);
        push(RQ_FALL, e0 + 6); push(BZ_FALL, e0 + 6);
        to_edge(e0 + 8); qsys_reset_n_sig = 1'b1;
        to_edge(e0 + 30);
        chk("t6_no_resume_rq", cpu_resetrequest, 0);
        chk("t6_no_resume_busy", busy, 0);

        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpureset_sequencer.md
# cpureset_sequencer

Parametrised CPU reset-request sequencer for the core clock domain (clock_core_sig), placed in the board top level between the asynchronous reset-request sources and the Nios II cpu_resetrequest/cpu_resettaken pair. It generalises the fixed 2-flop cpureset synchroniser in three ways:

- configurable synchroniser depth and number of request sources, with per-source masking;
- a resettaken handshake with minimum hold time and post-release guard time;
- a timeout path that asserts a hard reset when the CPU never acknowledges.

## Interface
- SYNC_STAGES, default 2, synchroniser flops per source (legal range 2..4).
- NUM_SRC, default 2, number of reset-request sources (1..8).
- HOLD_CYCLES, default 16, minimum cycles cpu_resetrequest stays high after resettaken.
- TIMEOUT_CYCLES, default 1024, cycles to wait for resettaken before forcing a hard reset.
- GUARD_CYCLES, default 8, cycles after release during which new requests are ignored.
- clock_core_sig  in  1  core clock; all logic is posedge.
- qsys_reset_n_sig  in  1  reset qsys_reset_n_sig, asynchronous, active-low; clock clock_core_sig.
- req_async  in  NUM_SRC  asynchronous reset-request levels, active-high.
- src_mask  in  NUM_SRC  quasi-static; 1 ignores that source.
- cpu_resettaken  in  1  from Nios II, synchronous to clock_core_sig.
- clear_status  in  1  single-cycle pulse; clears cause and timeout_flag.
- cpu_resetrequest  out  1  to Nios II.
- hard_reset_n  out  1  forced reset, active-low.
- busy  out  1  high when state is not IDLE.
- cause  out  NUM_SRC  sticky record of which sources triggered a sequence.
- timeout_flag  out  1  sticky; set on every entry to FORCE.

## Operation
- Synchroniser: each req_async bit passes through SYNC_STAGES flops, all reset to 0; req_sync is the last stage.
- req_any = |(req_sync & ~src_mask).
- Counter: cnt, width $clog2 of the maximum of (TIMEOUT_CYCLES, HOLD_CYCLES, GUARD_CYCLES), plus 1 bit. It clears on every state change.
- States and transitions:
  - IDLE: on req_any → REQ. On that transition cause |= req_sync & ~src_mask.
  - REQ: cpu_resetrequest=1; cnt increments every cycle.
    - cpu_resettaken=1 → HOLD.
    - Otherwise, when cnt==TIMEOUT_CYCLES-1 → FORCE, and timeout_flag is set.
    - If resettaken and the timeout coincide, resettaken wins.
  - HOLD: cpu_resetrequest=1; cnt saturates at HOLD_CYCLES-1. Exit → RELEASE only when the count has saturated and req_any=0. A source that stays high extends HOLD indefinitely.
  - FORCE: cpu_resetrequest=1, hard_reset_n=0. Same saturation and exit rule as HOLD.
  - RELEASE: cpu_resetrequest=0, hard_reset_n=1. After GUARD_CYCLES cycles → IDLE. req_any is ignored here and cause is not updated.
- Re-trigger: a request still (or newly) present on arrival in IDLE starts a new sequence on the next edge.
- clear_status clears cause and timeout_flag in any state. If a cause capture happens in the same cycle, the capture wins for the bits it sets.
- Changing src_mask mid-sequence affects only req_any evaluation from the next cycle onward.

## Timing
- All outputs are registered.
- Reset values: cpu_resetrequest=0, hard_reset_n=1, busy=0, cause=0, timeout_flag=0, state=IDLE, cnt=0, synchroniser flops 0.
- Request latency: a req_async rise sampled at edge k shows as cpu_resetrequest=1 after edge k+SYNC_STAGES (3 edges inclusive with the default).
- Acknowledge: resettaken sampled high at edge n → state=HOLD after edge n. cpu_resetrequest falls after edge n+HOLD_CYCLES at the earliest.
- Timeout: cpu_resetrequest rises at edge r → hard_reset_n=0 after edge r+TIMEOUT_CYCLES.
- busy changes on the same edge as the state changes.
- Reset asserted mid-sequence: everything returns immediately and asynchronously to reset values. No sequence resumes after reset deasserts; the synchroniser refills before any new request.

## Test plan
- Defaults; pulse req_async[0] for 4 cycles; assert resettaken 5 cycles after cpu_resetrequest rises. Required:
  - cpu_resetrequest rises 3 edges after sampling;
  - it stays high exactly 16 cycles after resettaken;
  - busy stays high a further 8 cycles;
  - cause=2'b01.
- Never assert resettaken. Required:
  - hard_reset_n=0 exactly 1024 cycles after cpu_resetrequest rises;
  - timeout_flag=1;
  - hard_reset_n stays low 16 cycles, then is released;
  - clear_status then returns timeout_flag to 0.
- src_mask=2'b10; pulse req_async[1]. Required: no sequence, busy stays 0, cause stays 0.
- Hold req_async[1] high for 100 cycles across HOLD. Required: cpu_resetrequest stays high until 16 cycles have elapsed and req_sync[1] has dropped; cause=2'b10.
- Assert req_async[0] during RELEASE. Required:
  - the request is ignored until IDLE;
  - a new REQ starts on the edge after IDLE is entered.
- Drive qsys_reset_n_sig low mid-REQ. Required: all outputs return to their reset values immediately, and no request is pending after release.
